// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit owning the HI/LO pair
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_wr_hi,
    input  logic                  i_wr_lo,
    input  logic                  i_abort,
    input  logic                  i_sel_hi,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    hi, lo;
    logic [W-1:0]    mag_m;
    logic [W-1:0]    raw_a;
    logic [2*W-1:0]  acc;
    logic            is_div, div_zero, sign_q, sign_r, done;

    logic            signed_op, a_neg, b_neg;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;

    assign signed_op = ~i_op[0];
    assign a_neg     = signed_op & i_a[W-1];
    assign b_neg     = signed_op & i_b[W-1];
    assign abs_a     = a_neg ? -i_a : i_a;
    assign abs_b     = b_neg ? -i_b : i_b;

    // Multiply keeps the multiplier in acc's low half and shifts it out as the product grows in.
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mag_m};
    // Divide keeps remainder in acc's high half and the dividend/quotient in the low half.
    assign div_shift = acc[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, mag_m};

    assign prod_fix  = sign_q ? -acc : acc;
    assign quo_fix   = sign_q ? -acc[W-1:0] : acc[W-1:0];
    assign rem_fix   = sign_r ? -acc[2*W-1:W] : acc[2*W-1:W];

    assign o_data    = i_sel_hi ? hi : lo;
    assign o_busy    = (state != IDLE);
    assign o_done    = done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mag_m    <= '0;
            raw_a    <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        is_div   <= i_op[1];
                        div_zero <= i_op[1] && (i_b == '0);
                        raw_a    <= i_a;
                        sign_q   <= a_neg ^ b_neg;
                        sign_r   <= a_neg;
                        mag_m    <= i_op[1] ? abs_b : abs_a;
                        acc      <= {{W{1'b0}}, (i_op[1] ? abs_a : abs_b)};
                        cnt      <= '0;
                        state    <= RUN;
                    end else begin
                        if (i_wr_hi) hi <= i_a;
                        if (i_wr_lo) lo <= i_a;
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (is_div) begin
                            if (!div_diff[W])
                                acc <= {div_diff[W-1:0], acc[W-2:0], 1'b1};
                            else
                                acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
                        end else if (acc[0]) begin
                            acc <= {mul_sum, acc[W-1:1]};
                        end else begin
                            acc <= {1'b0, acc[2*W-1:1]};
                        end
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!i_abort) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod_fix[2*W-1:W];
                            lo <= prod_fix[W-1:0];
                        end else if (div_zero) begin
                            hi <= raw_a;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
